// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates one entry per renamed instruction at the tail,
// accepts up to three completions per cycle, and retires the oldest entry once
// it is done, in program order, at most one per cycle.

// One ROB slot. The parent guarantees that allocation only targets a free
// slot, that completion only targets a valid slot that is not yet done, and
// that retirement only targets a slot that is done. So at most one of the
// three enables is active in any cycle.
module rob_entry #(
  parameter int PREG_WIDTH     = 6,
  parameter int AREG_WIDTH     = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic                      alloc_reg_write,
  input  logic [AREG_WIDTH-1:0]     alloc_areg,
  input  logic [PREG_WIDTH-1:0]     alloc_preg,
  input  logic [PREG_WIDTH-1:0]     alloc_old_preg,
  input  logic                      cpl_en,
  input  logic [REG_DATA_WIDTH-1:0] cpl_data,
  input  logic                      retire_en,
  output logic                      valid,
  output logic                      done,
  output logic                      reg_write,
  output logic [AREG_WIDTH-1:0]     areg,
  output logic [PREG_WIDTH-1:0]     preg,
  output logic [PREG_WIDTH-1:0]     old_preg,
  output logic [REG_DATA_WIDTH-1:0] data
);

  // Slot state: load on allocate, mark done on completion, free on retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      areg      <= '0;
      preg      <= '0;
      old_preg  <= '0;
      data      <= '0;
    end else if (alloc_en) begin
      valid     <= 1'b1;
      done      <= 1'b0;
      reg_write <= alloc_reg_write;
      areg      <= alloc_areg;
      preg      <= alloc_preg;
      old_preg  <= alloc_old_preg;
      data      <= '0;
    end else begin
      if (cpl_en) begin
        done <= 1'b1;
        data <= cpl_data;
      end
      if (retire_en) begin
        valid <= 1'b0;
        done  <= 1'b0;
      end
    end
  end

endmodule

module reorder_buffer #(
  parameter int DEPTH          = 64,
  parameter int IDX_WIDTH      = 6,
  parameter int PREG_WIDTH     = 6,
  parameter int AREG_WIDTH     = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic                        alloc_reg_write,
  input  logic [AREG_WIDTH-1:0]       alloc_areg,
  input  logic [PREG_WIDTH-1:0]       alloc_preg,
  input  logic [PREG_WIDTH-1:0]       alloc_old_preg,
  output logic [IDX_WIDTH-1:0]        rob_num,
  output logic                        full,
  output logic                        empty,
  output logic [IDX_WIDTH:0]          count,
  input  logic [2:0]                  complete_valid,
  input  logic [3*IDX_WIDTH-1:0]      complete_rob_num,
  input  logic [3*REG_DATA_WIDTH-1:0] complete_data,
  output logic                        retire_valid,
  output logic                        retire_reg_write,
  output logic [AREG_WIDTH-1:0]       retire_areg,
  output logic [PREG_WIDTH-1:0]       retire_preg,
  output logic [REG_DATA_WIDTH-1:0]   retire_data,
  output logic                        rob_push,
  output logic [PREG_WIDTH-1:0]       rob_free_reg
);

  localparam int NCPL = 3;
  localparam logic [IDX_WIDTH:0] PTR_ONE = 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_WIDTH:0]   head, tail;
  logic [IDX_WIDTH-1:0] head_idx, tail_idx;
  logic                 do_alloc;

  logic [DEPTH-1:0]                     ent_valid, ent_done, ent_reg_write;
  logic [DEPTH-1:0][AREG_WIDTH-1:0]     ent_areg;
  logic [DEPTH-1:0][PREG_WIDTH-1:0]     ent_preg, ent_old_preg;
  logic [DEPTH-1:0][REG_DATA_WIDTH-1:0] ent_data;

  assign head_idx = head[IDX_WIDTH-1:0];
  assign tail_idx = tail[IDX_WIDTH-1:0];
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[IDX_WIDTH] != tail[IDX_WIDTH]);
  assign count    = tail - head;
  assign rob_num  = tail_idx;
  assign do_alloc = alloc_valid & ~full;

  // The head retires as soon as it is done. Its fields read as zero otherwise.
  assign retire_valid     = ent_valid[head_idx] & ent_done[head_idx];
  assign retire_reg_write = retire_valid & ent_reg_write[head_idx];
  assign retire_areg      = retire_valid ? ent_areg[head_idx] : '0;
  assign retire_preg      = retire_valid ? ent_preg[head_idx] : '0;
  assign retire_data      = retire_valid ? ent_data[head_idx] : '0;
  assign rob_push         = retire_reg_write;
  assign rob_free_reg     = retire_valid ? ent_old_preg[head_idx] : '0;

  // Advance the tail on an accepted allocation and the head on a retirement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_alloc)     tail <= tail + PTR_ONE;
      if (retire_valid) head <= head + PTR_ONE;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic                      cpl_hit;
    logic [REG_DATA_WIDTH-1:0] cpl_d;

    // Find the completion aimed at this slot. Scanning from the top port down
    // lets the lowest-numbered port win.
    always_comb begin
      cpl_hit = 1'b0;
      cpl_d   = '0;
      for (int i = NCPL - 1; i >= 0; i--) begin
        if (complete_valid[i] &&
            complete_rob_num[i*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(g)) begin
          cpl_hit = 1'b1;
          cpl_d   = complete_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        end
      end
    end

    rob_entry #(
      .PREG_WIDTH    (PREG_WIDTH),
      .AREG_WIDTH    (AREG_WIDTH),
      .REG_DATA_WIDTH(REG_DATA_WIDTH)
    ) u_ent (
      .clk            (clk),
      .rst            (rst),
      .alloc_en       (do_alloc && (tail_idx == IDX_WIDTH'(g))),
      .alloc_reg_write(alloc_reg_write),
      .alloc_areg     (alloc_areg),
      .alloc_preg     (alloc_preg),
      .alloc_old_preg (alloc_old_preg),
      .cpl_en         (cpl_hit & ent_valid[g] & ~ent_done[g]),
      .cpl_data       (cpl_d),
      .retire_en      (retire_valid && (head_idx == IDX_WIDTH'(g))),
      .valid          (ent_valid[g]),
      .done           (ent_done[g]),
      .reg_write      (ent_reg_write[g]),
      .areg           (ent_areg[g]),
      .preg           (ent_preg[g]),
      .old_preg       (ent_old_preg[g]),
      .data           (ent_data[g])
    );
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a table of directed vectors, a few hand-written
// multi-cycle sequences, and a randomized run, all compared against a
// queue-based program-order model of the buffer.
module tb_reorder_buffer;

  localparam int DEPTH = 64;
  localparam int IW    = 6;
  localparam int PW    = 6;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic            clk, rst;
  logic            alloc_valid, alloc_reg_write;
  logic [AW-1:0]   alloc_areg;
  logic [PW-1:0]   alloc_preg, alloc_old_preg;
  logic [IW-1:0]   rob_num;
  logic            full, empty;
  logic [IW:0]     count;
  logic [2:0]      complete_valid;
  logic [3*IW-1:0] complete_rob_num;
  logic [3*DW-1:0] complete_data;
  logic            retire_valid, retire_reg_write;
  logic [AW-1:0]   retire_areg;
  logic [PW-1:0]   retire_preg;
  logic [DW-1:0]   retire_data;
  logic            rob_push;
  logic [PW-1:0]   rob_free_reg;

  reorder_buffer #(.DEPTH(DEPTH), .IDX_WIDTH(IW), .PREG_WIDTH(PW),
                   .AREG_WIDTH(AW), .REG_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write),
    .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
    .rob_num(rob_num), .full(full), .empty(empty), .count(count),
    .complete_valid(complete_valid), .complete_rob_num(complete_rob_num),
    .complete_data(complete_data),
    .retire_valid(retire_valid), .retire_reg_write(retire_reg_write),
    .retire_areg(retire_areg), .retire_preg(retire_preg), .retire_data(retire_data),
    .rob_push(rob_push), .rob_free_reg(rob_free_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: entries in program order ----------------
  typedef struct {
    logic          rw;
    logic [AW-1:0] areg;
    logic [PW-1:0] preg;
    logic [PW-1:0] old;
    logic          done;
    logic [DW-1:0] data;
  } ment_t;

  ment_t q[$];
  int    mhead = 0;  // entries ever retired
  int    mtail = 0;  // entries ever allocated

  function automatic void model_reset();
    q.delete();
    mhead = 0;
    mtail = 0;
  endfunction

  // Apply one clock edge of the current inputs, using pre-edge state for
  // every decision.
  function automatic void model_step();
    bit    ret, fl;
    ment_t e;
    ret = (q.size() > 0) && q[0].done;
    fl  = (q.size() == DEPTH);
    for (int i = 0; i < 3; i++) begin
      if (complete_valid[i]) begin
        int k, p;
        k = int'(complete_rob_num[i*IW +: IW]);
        p = (k - (mhead % DEPTH) + DEPTH) % DEPTH;
        if (p < q.size() && !q[p].done) begin
          e = q[p];
          e.done = 1'b1;
          e.data = complete_data[i*DW +: DW];
          q[p] = e;
        end
      end
    end
    if (ret) begin
      void'(q.pop_front());
      mhead++;
    end
    if (alloc_valid && !fl) begin
      e.rw = alloc_reg_write; e.areg = alloc_areg; e.preg = alloc_preg;
      e.old = alloc_old_preg; e.done = 1'b0; e.data = '0;
      q.push_back(e);
      mtail++;
    end
  endfunction

  task automatic mcheck();
    bit rv;
    rv = (q.size() > 0) && q[0].done;
    chk("rob_num", rob_num, 64'(mtail % DEPTH));
    chk("count", count, 64'(q.size()));
    chk("full", full, 64'(q.size() == DEPTH));
    chk("empty", empty, 64'(q.size() == 0));
    chk("retire_valid", retire_valid, 64'(rv));
    if (rv) begin
      chk("retire_reg_write", retire_reg_write, 64'(q[0].rw));
      chk("retire_areg", retire_areg, 64'(q[0].areg));
      chk("retire_preg", retire_preg, 64'(q[0].preg));
      chk("retire_data", retire_data, 64'(q[0].data));
      chk("rob_push", rob_push, 64'(q[0].rw));
      if (q[0].rw) chk("rob_free_reg", rob_free_reg, 64'(q[0].old));
    end else begin
      chk("rob_push_idle", rob_push, 64'(0));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr_in();
    alloc_valid = 0; alloc_reg_write = 0; alloc_areg = '0;
    alloc_preg = '0; alloc_old_preg = '0;
    complete_valid = '0; complete_rob_num = '0; complete_data = '0;
  endtask

  task automatic set_alloc(input logic rw, input int a, input int p, input int o);
    alloc_valid = 1; alloc_reg_write = rw;
    alloc_areg = AW'(a); alloc_preg = PW'(p); alloc_old_preg = PW'(o);
  endtask

  task automatic set_cpl(input int port, input int rn, input logic [DW-1:0] d);
    complete_valid[port] = 1'b1;
    complete_rob_num[port*IW +: IW] = IW'(rn);
    complete_data[port*DW +: DW] = d;
  endtask

  // One cycle: inputs are already driven at a falling edge; let the rising
  // edge happen, then compare at the next falling edge and clear inputs.
  task automatic step();
    model_step();
    @(negedge clk);
    mcheck();
    clr_in();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    #1;
    chk("rst_empty", empty, 64'(1));
    chk("rst_full", full, 64'(0));
    chk("rst_count", count, 64'(0));
    chk("rst_rob_num", rob_num, 64'(0));
    chk("rst_retire_valid", retire_valid, 64'(0));
    chk("rst_rob_push", rob_push, 64'(0));
    chk("rst_retire_data", retire_data, 64'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    mcheck();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          av, rw;
    logic [AW-1:0] areg;
    logic [PW-1:0] preg, old;
    logic [2:0]    cv;
    logic [3*IW-1:0] crn;
    logic [3*DW-1:0] cd;
    logic [IW:0]   ecount;
    logic [IW-1:0] erob;
    logic          erv, epush;
    logic [PW-1:0] efree;
    logic [DW-1:0] edata;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mkv(input logic av, rw, input int a, p, o,
                               input logic [2:0] cv, input int r0, r1, r2,
                               input logic [DW-1:0] d0, d1, d2,
                               input int ecnt, erob, input logic erv, epush,
                               input int efree, input logic [DW-1:0] edata);
    vec_t v;
    v.av = av; v.rw = rw; v.areg = AW'(a); v.preg = PW'(p); v.old = PW'(o);
    v.cv = cv; v.crn = {IW'(r2), IW'(r1), IW'(r0)}; v.cd = {d2, d1, d0};
    v.ecount = (IW+1)'(ecnt); v.erob = IW'(erob); v.erv = erv; v.epush = epush;
    v.efree = PW'(efree); v.edata = edata;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    clr_in();
    // in-order retire: allocate 0..2, complete out of order
    tv[0]  = mkv(1,1,1,20,10, 3'b000,0,0,0, 0,0,0,            1,1, 0,0,0,  0);
    tv[1]  = mkv(1,1,2,21,11, 3'b000,0,0,0, 0,0,0,            2,2, 0,0,0,  0);
    tv[2]  = mkv(1,1,3,22,12, 3'b000,0,0,0, 0,0,0,            3,3, 0,0,0,  0);
    tv[3]  = mkv(0,0,0,0,0,   3'b001,2,0,0, 32'h222,0,0,      3,3, 0,0,0,  0);
    tv[4]  = mkv(0,0,0,0,0,   3'b010,0,1,0, 0,32'h111,0,      3,3, 0,0,0,  0);
    tv[5]  = mkv(0,0,0,0,0,   3'b100,0,0,0, 0,0,32'h100,      3,3, 1,1,10, 32'h100);
    tv[6]  = mkv(0,0,0,0,0,   3'b000,0,0,0, 0,0,0,            2,3, 1,1,11, 32'h111);
    tv[7]  = mkv(0,0,0,0,0,   3'b000,0,0,0, 0,0,0,            1,3, 1,1,12, 32'h222);
    tv[8]  = mkv(0,0,0,0,0,   3'b000,0,0,0, 0,0,0,            0,3, 0,0,0,  0);
    // non-writing entry, two ports racing on it, then alloc alongside retire
    tv[9]  = mkv(1,0,4,23,13, 3'b000,0,0,0, 0,0,0,            1,4, 0,0,0,  0);
    tv[10] = mkv(0,0,0,0,0,   3'b101,3,0,3, 32'hAAAA,0,32'h5555, 1,4, 1,0,0, 32'hAAAA);
    tv[11] = mkv(1,1,5,24,14, 3'b000,0,0,0, 0,0,0,            1,5, 0,0,0,  0);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      alloc_valid = tv[i].av; alloc_reg_write = tv[i].rw; alloc_areg = tv[i].areg;
      alloc_preg = tv[i].preg; alloc_old_preg = tv[i].old;
      complete_valid = tv[i].cv; complete_rob_num = tv[i].crn; complete_data = tv[i].cd;
      step();
      chk($sformatf("tv%0d_count", i), count, 64'(tv[i].ecount));
      chk($sformatf("tv%0d_rob_num", i), rob_num, 64'(tv[i].erob));
      chk($sformatf("tv%0d_retire_valid", i), retire_valid, 64'(tv[i].erv));
      if (tv[i].erv) begin
        chk($sformatf("tv%0d_rob_push", i), rob_push, 64'(tv[i].epush));
        chk($sformatf("tv%0d_retire_data", i), retire_data, 64'(tv[i].edata));
        if (tv[i].epush) chk($sformatf("tv%0d_free", i), rob_free_reg, 64'(tv[i].efree));
      end
    end

    // mid-stream reset with five entries live
    for (int i = 0; i < 4; i++) begin
      set_alloc(1, i, 30 + i, 40 + i);
      step();
    end
    chk("pre_reset_count", count, 64'(5));
    do_reset();

    // stale completion to an unallocated slot must not pre-mark it done
    set_cpl(0, 7, 32'hDEAD);
    step();
    chk("stale_count", count, 64'(0));
    for (int i = 0; i < 8; i++) begin
      set_alloc(1, i, i, 50 + i);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      set_cpl(1, i, DW'(i));
      step();
    end
    for (int i = 0; i < 8 && count > 1; i++) step();
    chk("stale_count_left", count, 64'(1));
    chk("stale_not_done", retire_valid, 64'(0));
    set_cpl(2, 7, 32'h7777);
    step();
    chk("stale_late_retire", retire_data, 64'(32'h7777));
    step();

    // fill to full, overflow attempt, retire the head, then wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1, i % 32, i, (i + 1) % 64);
      step();
    end
    chk("full_flag", full, 64'(1));
    chk("full_count", count, 64'(DEPTH));
    set_alloc(1, 9, 9, 9);
    step();
    chk("overflow_count", count, 64'(DEPTH));
    chk("overflow_rob_num", rob_num, 64'(0));
    set_cpl(0, 0, 32'h77);
    set_alloc(1, 9, 9, 9);
    step();
    chk("full_head_done", retire_valid, 64'(1));
    chk("full_still", full, 64'(1));
    set_alloc(1, 9, 9, 9);
    step();
    chk("after_retire_count", count, 64'(DEPTH - 1));
    chk("after_retire_full", full, 64'(0));
    chk("wrap_rob_num", rob_num, 64'(0));
    set_alloc(1, 10, 10, 10);
    step();
    chk("wrap_full_again", full, 64'(1));
    chk("wrap_rob_num_next", rob_num, 64'(1));

    // randomized traffic: balanced phase, then allocation-heavy phase
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int arate, crate;
      arate = (c < 2000) ? 60 : 92;
      crate = (c < 2000) ? 45 : 12;
      if ($urandom_range(0, 99) < arate)
        set_alloc(1'($urandom), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 99) < crate) begin
          int tgt;
          if (q.size() > 0 && $urandom_range(0, 99) < 85)
            tgt = (mhead + int'($urandom_range(0, q.size() - 1))) % DEPTH;
          else
            tgt = int'($urandom_range(0, DEPTH - 1));
          set_cpl(p, tgt, $urandom);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
